// File: rtl/reservation_station_cdb.sv
// Tomasulo reservation station with CDB snoop and age-ordered dispatch.
// Define RS_CDB_BYPASS_EN to capture a same-cycle CDB result at issue.
module reservation_station_cdb #(
    parameter int DEPTH    = 8,
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 4,
    parameter int OP_W     = 4,
    parameter int TAG_BASE = 1
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_W-1:0]            in_op,
    input  logic [TAG_W-1:0]           in_qj,
    input  logic [TAG_W-1:0]           in_qk,
    input  logic [DATA_W-1:0]          in_vj,
    input  logic [DATA_W-1:0]          in_vk,
    output logic [TAG_W-1:0]           in_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    output logic                       ex_valid,
    input  logic                       ex_ready,
    output logic [OP_W-1:0]            ex_op,
    output logic [DATA_W-1:0]          ex_a,
    output logic [DATA_W-1:0]          ex_b,
    output logic [TAG_W-1:0]           ex_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  busy_q, busy_d, rdy, sel_oh;
    logic [OP_W-1:0]   op_q[DEPTH], op_d[DEPTH];
    logic [TAG_W-1:0]  qj_q[DEPTH], qj_d[DEPTH], qk_q[DEPTH], qk_d[DEPTH];
    logic [DATA_W-1:0] vj_q[DEPTH], vj_d[DEPTH], vk_q[DEPTH], vk_d[DEPTH];
    // age_q[i][j] set means entry j is older than entry i
    logic [DEPTH-1:0]  age_q[DEPTH], age_d[DEPTH];

    logic              ex_valid_q, ex_valid_d;
    logic [OP_W-1:0]   ex_op_q, ex_op_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic [TAG_W-1:0]  ex_tag_q, ex_tag_d;

    logic [CW-1:0] cnt;
    logic [IW-1:0] free_idx, sel_idx;
    logic          has_sel, cdb_hit, stall, accept, dispatch;

    always_comb begin
        cnt      = '0;
        rdy      = '0;
        free_idx = '0;
        sel_idx  = '0;
        has_sel  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt    = cnt + CW'(busy_q[i]);
            rdy[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
        end
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IW'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i] && ((age_q[i] & rdy) == '0)) begin
                sel_idx = IW'(i);
                has_sel = 1'b1;
            end
        end
    end

    assign cdb_hit = cdb_valid && (cdb_tag != '0);
`ifdef RS_CDB_BYPASS_EN
    assign stall = 1'b0;
`else
    assign stall = cdb_hit && ((cdb_tag == in_qj) || (cdb_tag == in_qk));
`endif
    assign in_ready = (cnt < CW'(DEPTH)) && !flush && !stall;
    assign accept   = in_valid && in_ready;
    assign dispatch = has_sel && (!ex_valid_q || ex_ready) && !flush;
    assign sel_oh   = dispatch ? ({{(DEPTH-1){1'b0}}, 1'b1} << sel_idx) : '0;

    always_comb begin
        busy_d     = busy_q;
        op_d       = op_q;
        qj_d       = qj_q;
        qk_d       = qk_q;
        vj_d       = vj_q;
        vk_d       = vk_q;
        age_d      = age_q;
        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_tag_d   = ex_tag_q;
        if (flush) begin
            busy_d     = '0;
            ex_valid_d = 1'b0;
            for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && cdb_hit && (qj_q[i] == cdb_tag)) begin
                    qj_d[i] = '0;
                    vj_d[i] = cdb_data;
                end
                if (busy_q[i] && cdb_hit && (qk_q[i] == cdb_tag)) begin
                    qk_d[i] = '0;
                    vk_d[i] = cdb_data;
                end
            end
            if (dispatch) begin
                busy_d[sel_idx] = 1'b0;
                ex_valid_d      = 1'b1;
                ex_op_d         = op_q[sel_idx];
                ex_a_d          = vj_q[sel_idx];
                ex_b_d          = vk_q[sel_idx];
                ex_tag_d        = TAG_W'(TAG_BASE) + TAG_W'(sel_idx);
            end else if (ex_ready) begin
                ex_valid_d = 1'b0;
            end
            if (accept) begin
                busy_d[free_idx] = 1'b1;
                op_d[free_idx]   = in_op;
                qj_d[free_idx]   = in_qj;
                qk_d[free_idx]   = in_qk;
                vj_d[free_idx]   = in_vj;
                vk_d[free_idx]   = in_vk;
`ifdef RS_CDB_BYPASS_EN
                if (cdb_hit && (in_qj == cdb_tag)) begin
                    qj_d[free_idx] = '0;
                    vj_d[free_idx] = cdb_data;
                end
                if (cdb_hit && (in_qk == cdb_tag)) begin
                    qk_d[free_idx] = '0;
                    vk_d[free_idx] = cdb_data;
                end
`endif
                for (int j = 0; j < DEPTH; j++) age_d[j][free_idx] = 1'b0;
                age_d[free_idx] = busy_q & ~sel_oh;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_tag_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                age_q[i] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            op_q       <= op_d;
            qj_q       <= qj_d;
            qk_q       <= qk_d;
            vj_q       <= vj_d;
            vk_q       <= vk_d;
            age_q      <= age_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_tag_q   <= ex_tag_d;
        end
    end

    assign in_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
    assign ex_valid = ex_valid_q;
    assign ex_op    = ex_op_q;
    assign ex_a     = ex_a_q;
    assign ex_b     = ex_b_q;
    assign ex_tag   = ex_tag_q;
    assign count    = cnt;
endmodule
